// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment binary-to-digit converter.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DIGITS      = 4;
    localparam int BCD_NIBBLES = 5;
    localparam int SHIFT_STEPS = 16;
    localparam int CNT_W       = 5;

    localparam logic [3:0] SAT_DIGIT = 4'd9;

endpackage

// File: rtl/dd_nibble_adjust.sv
// Double-dabble correction: a BCD nibble of 5 or more gets +3 before the shift.
module dd_nibble_adjust (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/disp_bcd_converter.sv
// Converts a 16-bit value into four display digits, either as a hex split or
// via a serial double-dabble; digits hold steady until the next result load.
module disp_bcd_converter
    import disp_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             hex_mode,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       dig3,
    output logic [3:0]       dig2,
    output logic [3:0]       dig1,
    output logic [3:0]       dig0
);

    if (WIDTH != 16) begin : g_width_check
        $error("disp_bcd_converter: WIDTH must be 16");
    end

    state_e                   state_q, state_d;
    logic [WIDTH-1:0]         sreg_q, sreg_d;
    logic [4*BCD_NIBBLES-1:0] bcd_q, bcd_d, bcd_adj, bcd_shift;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [4*DIGITS-1:0]      dig_q, dig_d;
    logic                     ovf_q, ovf_d;

    for (genvar n = 0; n < BCD_NIBBLES; n++) begin : g_adj
        dd_nibble_adjust u_adj (
            .nib_i (bcd_q[4*n +: 4]),
            .nib_o (bcd_adj[4*n +: 4])
        );
    end

    assign bcd_shift = {bcd_adj[4*BCD_NIBBLES-2:0], sreg_q[WIDTH-1]};

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (hex_mode) begin
                        dig_d   = value;
                        ovf_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        sreg_d  = value;
                        bcd_d   = '0;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sreg_d = sreg_q << 1;
                bcd_d  = bcd_shift;
                cnt_d  = cnt_q + 1'b1;
                // The final step loads the result straight from the shifted value.
                if (cnt_q == CNT_W'(SHIFT_STEPS - 1)) begin
                    state_d = DONE;
                    if (bcd_shift[4*BCD_NIBBLES-1 -: 4] != 4'd0) begin
                        ovf_d = 1'b1;
                        dig_d = SATURATE ? {DIGITS{SAT_DIGIT}} : bcd_shift[4*DIGITS-1:0];
                    end else begin
                        ovf_d = 1'b0;
                        dig_d = bcd_shift[4*DIGITS-1:0];
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign ovf  = ovf_q;
    assign dig3 = dig_q[15:12];
    assign dig2 = dig_q[11:8];
    assign dig1 = dig_q[7:4];
    assign dig0 = dig_q[3:0];

endmodule

// File: tb/tb_disp_bcd_converter.sv
// Bench for disp_bcd_converter: saturating and wrapping instances share stimulus.
module tb_disp_bcd_converter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        hex_mode = 1'b0;
    logic [15:0] value = '0;

    logic       a_busy, a_done, a_ovf;
    logic [3:0] a_d3, a_d2, a_d1, a_d0;
    logic       b_busy, b_done, b_ovf;
    logic [3:0] b_d3, b_d2, b_d1, b_d0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    disp_bcd_converter #(.WIDTH(16), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset_n(reset_n), .start(start), .hex_mode(hex_mode), .value(value),
        .busy(a_busy), .done(a_done), .ovf(a_ovf),
        .dig3(a_d3), .dig2(a_d2), .dig1(a_d1), .dig0(a_d0)
    );

    disp_bcd_converter #(.WIDTH(16), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset_n(reset_n), .start(start), .hex_mode(hex_mode), .value(value),
        .busy(b_busy), .done(b_done), .ovf(b_ovf),
        .dig3(b_d3), .dig2(b_d2), .dig1(b_d1), .dig0(b_d0)
    );

    wire [15:0] a_dig = {a_d3, a_d2, a_d1, a_d0};
    wire [15:0] b_dig = {b_d3, b_d2, b_d1, b_d0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: what the display should read for a given request.
    function automatic void model(input logic hm, input logic [15:0] v, input bit sat,
                                  output logic [15:0] d, output logic o);
        int n;
        if (hm) begin
            d = v;
            o = 1'b0;
        end else begin
            n = int'(v);
            o = (n > 9999);
            if (n > 9999) n = sat ? 9999 : n % 10000;
            d = {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
        end
    endfunction

    task automatic run_conv(input logic hm, input logic [15:0] v, input string tag);
        logic [15:0] ea, eb, prev;
        logic        oa, ob;
        int          bc, dc;
        model(hm, v, 1'b1, ea, oa);
        model(hm, v, 1'b0, eb, ob);
        @(posedge clk); #1;
        prev = a_dig;
        start = 1'b1; hex_mode = hm; value = v;
        @(posedge clk); #1;
        start = 1'b0; hex_mode = ~hm; value = ~v;
        bc = 0; dc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!a_busy) break;
            bc++;
            if (a_done) begin
                dc++;
                chk({tag, "_dig_sat"},  a_dig, ea);
                chk({tag, "_ovf_sat"},  a_ovf, oa);
                chk({tag, "_dig_wrap"}, b_dig, eb);
                chk({tag, "_ovf_wrap"}, b_ovf, ob);
            end else begin
                chk({tag, "_hold"}, a_dig, prev);
            end
        end
        chk({tag, "_busy_cycles"}, bc, hm ? 1 : 17);
        chk({tag, "_done_pulses"}, dc, 1);
    endtask

    initial begin
        int          bc, dc, idle;
        logic [15:0] rv;
        logic        rh;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_ovf",  a_ovf, 0);
        chk("rst_dig",  a_dig, 0);
        chk("rst_dig_wrap", b_dig, 0);
        @(posedge clk); #1 reset_n = 1'b1;

        // Basic decimal and boundaries
        run_conv(1'b0, 16'h04D2, "dec1234");
        run_conv(1'b0, 16'h270F, "dec9999");
        run_conv(1'b0, 16'h2710, "dec10000");
        run_conv(1'b0, 16'hFFFF, "decFFFF");
        run_conv(1'b0, 16'h0000, "dec0");
        run_conv(1'b0, 16'h2710, "pre_hex_ovf");
        chk("ovf_before_hex", a_ovf, 1);
        run_conv(1'b1, 16'hBEEF, "hexBEEF");

        // Start pulse during a conversion is ignored
        @(posedge clk); #1 start = 1'b1; hex_mode = 1'b0; value = 16'h04D2;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1; hex_mode = 1'b1; value = 16'h1111;
        @(posedge clk); #1 start = 1'b0;
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!a_busy) break;
            if (a_done) begin
                dc++;
                chk("ign_dig", a_dig, 16'h1234);
                chk("ign_ovf", a_ovf, 0);
            end
        end
        chk("ign_done_pulses", dc, 1);
        repeat (2) begin
            @(negedge clk);
            chk("ign_no_restart", a_busy, 0);
        end

        // Asynchronous reset mid-conversion
        @(posedge clk); #1 start = 1'b1; hex_mode = 1'b0; value = 16'h2222;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", a_busy, 0);
        chk("arst_done", a_done, 0);
        chk("arst_ovf",  a_ovf, 0);
        chk("arst_dig",  a_dig, 0);
        dc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (a_done) dc++;
        end
        chk("arst_no_done", dc, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        run_conv(1'b0, 16'h2222, "after_arst");

        // start held high: back-to-back conversions
        @(posedge clk); #1 start = 1'b1; hex_mode = 1'b0; value = 16'h0007;
        dc = 0;
        for (int i = 0; i < 40 && dc == 0; i++) begin
            @(negedge clk);
            if (a_done) dc++;
        end
        chk("hold_first_done", dc, 1);
        chk("hold_first_dig", a_dig, 16'h0007);
        value = 16'h0063;
        @(negedge clk);
        idle = 0;
        for (int i = 0; i < 10 && !a_busy; i++) begin
            idle++;
            @(negedge clk);
        end
        chk("hold_idle_gap", idle, 1);
        dc = 0;
        for (int i = 0; i < 40 && dc == 0; i++) begin
            @(negedge clk);
            if (a_done) dc++;
        end
        chk("hold_second_done", dc, 1);
        chk("hold_second_dig", a_dig, 16'h0099);
        chk("hold_second_ovf", a_ovf, 0);
        @(posedge clk); #1 start = 1'b0;
        bc = 0;
        for (int i = 0; i < 40 && a_busy; i++) begin
            @(negedge clk);
            bc++;
        end
        chk("hold_settle", a_busy, 0);

        // Randomized requests against the model
        for (int i = 0; i < 24; i++) begin
            rv = 16'($urandom);
            if ($urandom_range(0, 2) == 0) rv = 16'($urandom_range(9990, 10010));
            rh = 1'($urandom_range(0, 3) == 0);
            run_conv(rh, rv, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/disp_bcd_converter.md
Name: disp_bcd_converter

Overview:
Sequential binary-to-digit converter that sits directly upstream of the 4-digit seven-segment multiplexer and drives its four nibble inputs. It takes a 16-bit datapath value (PC, register or ALU result selected by board logic) and produces four display digits. In hex mode it splits the value into four nibbles. In decimal mode it runs a serial double-dabble conversion. Outputs are held stable between conversions, so the display never shows intermediate values.

Parameters:
WIDTH, 16, input value width; fixed at 16, and any other value is a configuration error.
SATURATE, 1, 1: decimal results above 9999 display as 9999; 0: display the result mod 10000. Both settings raise ovf.

Ports:
clk  input  1  system clock (100 MHz)
reset_n  input  1  asynchronous, active-low reset
start  input  1  request a conversion; sampled only in IDLE
hex_mode  input  1  1: hex split, 0: decimal conversion; sampled together with start
value  input  16  binary value to convert; sampled together with start
busy  output  1  high while a conversion is in progress (SHIFT or DONE)
done  output  1  single-cycle pulse; the new digits are valid in this cycle
ovf  output  1  last decimal result exceeded 9999; cleared by any hex conversion
dig3  output  4  most significant display digit (drives the multiplexer's in3)
dig2  output  4  drives in2
dig1  output  4  drives in1
dig0  output  4  least significant digit (drives in0)

Behaviour:
- Reset is asynchronous and active-low. While reset_n is low: state=IDLE; busy=0, done=0, ovf=0; dig3..dig0=0; internal shift and BCD registers cleared.
- Reset asserted mid-conversion aborts the conversion immediately; no done pulse is produced.
- State machine states are IDLE, SHIFT and DONE. busy = (state != IDLE). done = (state == DONE).
- IDLE, start=1, hex_mode=1 at edge k:
  - dig3..dig0 <= value[15:12], value[11:8], value[7:4], value[3:0]; ovf <= 0.
  - state -> DONE; done is high for the one cycle after edge k; edge k+1 returns to IDLE.
- IDLE, start=1, hex_mode=0 at edge k:
  - sreg <= value; bcd (20 bits, 5 nibbles) <= 0; cnt <= 0; state -> SHIFT.
- SHIFT, one step per cycle:
  - Each bcd nibble >= 5 gets +3 (combinational).
  - Then {bcd, sreg} shifts left by 1; cnt increments.
  - After the 16th step (edge k+16), state -> DONE and the result registers load in that same edge.
- Result load:
  - If the ten-thousands nibble != 0: ovf <= 1; digits <= 9,9,9,9 if SATURATE=1, else the low 4 BCD nibbles.
  - Otherwise: ovf <= 0; digits <= the low 4 BCD nibbles.
- Decimal latency: done is high in the cycle after edge k+16 and the FSM is back in IDLE after edge k+17. busy is high for 17 cycles.
- start while busy is ignored: no queuing, inputs are not re-sampled, and the active conversion is unaffected.
- start held high continuously: a new conversion begins on the first IDLE edge, i.e. back-to-back with one IDLE cycle between conversions.
- dig*, ovf change only on a result load (or reset). They are stable throughout SHIFT.
- cnt is 5 bits and wraps only via the state exit; it never exceeds 16.

Decomposition:
- Package disp_pkg holds:
  - state enum {IDLE, SHIFT, DONE}
  - DIGITS=4, BCD_NIBBLES=5, SHIFT_STEPS=16
  - SAT_DIGIT=4'd9
- One combinational sub-module dd_nibble_adjust: 4-bit in -> 4-bit out, adds 3 if the input is >= 5. It is instantiated 5 times inside the shift datapath.

Test Plan:
1. Reset, then start in decimal mode with value=0x04D2 (1234) -> busy high 17 cycles; done pulse in the cycle after edge k+16; dig3..0 = 1,2,3,4; ovf=0.
2. Decimal boundaries: 0x270F (9999) -> 9,9,9,9 with ovf=0. 0x2710 (10000) -> 9,9,9,9 with ovf=1. 0xFFFF with SATURATE=0 -> 5,5,3,5 with ovf=1. 0x0000 -> 0,0,0,0 with ovf=0.
3. Hex mode with value=0xBEEF, following a run that left ovf=1 -> done in the cycle after edge k; dig = B,E,E,F; ovf=0; busy high exactly 1 cycle.
4. Start 1234 in decimal mode, then pulse start with value=0x1111 at cycle k+5 -> the second request is ignored; result is 1,2,3,4 with a single done pulse.
5. Assert reset_n low at cycle k+8 of a decimal conversion of 0x2222 -> all outputs 0 immediately with no clock edge needed; no done pulse; a new start after release converts correctly.
6. start held high across two conversions (0x0007, then 0x0063 presented after the first done) -> dig shows 0,0,0,7 then 0,0,9,9; one IDLE cycle between the two busy periods.
